// File: rtl/matrix_uart_formatter.sv
// Reads an m x n matrix from storage in row-major order and streams it as ASCII
// decimal text (space-separated, CR LF per row) over a valid/ready byte interface.
module matrix_uart_formatter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [31:0]       i_m,
  input  logic [31:0]       i_n,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [7:0]        o_byte,
  output logic              o_byte_valid,
  input  logic              i_byte_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int DIM_W = $clog2(MAX_DIM + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RD_ADDR, S_RD_WAIT, S_CONV,
    S_EMIT_DIG, S_EMIT_SP, S_EMIT_CR, S_EMIT_LF, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       m_q, m_d;
  logic [31:0]       n_q, n_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [7:0]        val_q, val_d;
  logic [3:0][7:0]   dig_q, dig_d;
  logic [1:0]        ndig_q, ndig_d;
  logic [1:0]        idx_q, idx_d;
  logic              err_q, err_d;

  logic [DIM_W-1:0]  m_dim, n_dim;
  logic [7:0]        hund, tens, units;
  logic              accept;

  assign m_dim = m_q[DIM_W-1:0];
  assign n_dim = n_q[DIM_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      m_q     <= '0;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      val_q   <= '0;
      dig_q   <= '0;
      ndig_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      m_q     <= m_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      val_q   <= val_d;
      dig_q   <= dig_d;
      ndig_q  <= ndig_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    m_d     = m_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    val_d   = val_q;
    dig_d   = dig_q;
    ndig_d  = ndig_q;
    idx_d   = idx_q;
    err_d   = err_q;

    o_byte       = '0;
    o_byte_valid = state_q inside {S_EMIT_DIG, S_EMIT_SP, S_EMIT_CR, S_EMIT_LF};
    accept       = o_byte_valid && i_byte_ready;

    hund  = val_q / 8'd100;
    tens  = (val_q / 8'd10) % 8'd10;
    units = val_q % 8'd10;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          base_d  = i_base_addr;
          m_d     = i_m;
          n_d     = i_n;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((m_q == '0) || (n_q == '0) ||
            (m_q > 32'(MAX_DIM)) || (n_q > 32'(MAX_DIM))) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          row_d   = '0;
          col_d   = '0;
          addr_d  = base_q;
          state_d = S_RD_ADDR;
        end
      end
      S_RD_ADDR: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        val_d   = (|i_rd_data[DATA_W-1:8]) ? 8'hFF : i_rd_data[7:0];
        state_d = S_CONV;
      end
      S_CONV: begin
        // Digits are packed most-significant first so emission just walks idx 0..ndig-1.
        dig_d = '0;
        if (hund != 8'd0) begin
          dig_d[0] = 8'h30 + hund;
          dig_d[1] = 8'h30 + tens;
          dig_d[2] = 8'h30 + units;
          ndig_d   = 2'd3;
        end else if (tens != 8'd0) begin
          dig_d[0] = 8'h30 + tens;
          dig_d[1] = 8'h30 + units;
          ndig_d   = 2'd2;
        end else begin
          dig_d[0] = 8'h30 + units;
          ndig_d   = 2'd1;
        end
        idx_d   = '0;
        state_d = S_EMIT_DIG;
      end
      S_EMIT_DIG: begin
        o_byte = dig_q[idx_q];
        if (accept) begin
          if (idx_q == ndig_q - 2'd1) begin
            state_d = (col_q + DIM_W'(1) == n_dim) ? S_EMIT_CR : S_EMIT_SP;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_EMIT_SP: begin
        o_byte = 8'h20;
        if (accept) begin
          col_d   = col_q + DIM_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_RD_ADDR;
        end
      end
      S_EMIT_CR: begin
        o_byte = 8'h0D;
        if (accept) state_d = S_EMIT_LF;
      end
      S_EMIT_LF: begin
        o_byte = 8'h0A;
        if (accept) begin
          if (row_q + DIM_W'(1) == m_dim) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + DIM_W'(1);
            col_d   = '0;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = S_RD_ADDR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign o_rd_addr = addr_q;
  assign o_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done    = (state_q == S_DONE);
  assign o_err     = (state_q == S_DONE) && err_q;

endmodule

// File: tb/tb_matrix_uart_formatter.sv
// Self-checking bench: storage model plus a text-level reference of the expected ASCII stream.
module tb_matrix_uart_formatter;

  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_base_addr = '0;
  logic [31:0] i_m = '0;
  logic [31:0] i_n = '0;
  logic [7:0]  o_rd_addr;
  logic [31:0] i_rd_data = '0;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready = 1'b1;
  logic        o_busy, o_done, o_err;

  logic [31:0] mem [256];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  exp_addr[$];
  logic [7:0]  got_addr[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  matrix_uart_formatter #(.ADDR_W(8), .DATA_W(32), .MAX_DIM(5)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_m(i_m), .i_n(i_n), .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) i_rd_data <= mem[o_rd_addr];

  // Reference: render the matrix as decimal text exactly as a terminal would show it.
  function automatic void build_expected(input logic [7:0] base, input int m, input int n);
    string s;
    int unsigned v;
    logic [7:0] a;
    exp_q.delete();
    exp_addr.delete();
    for (int r = 0; r < m; r++) begin
      for (int c = 0; c < n; c++) begin
        a = 8'(int'(base) + r * n + c);
        exp_addr.push_back(a);
        v = (mem[a] > 32'd255) ? 255 : int'(mem[a]);
        s = $sformatf("%0d", v);
        for (int k = 0; k < s.len(); k++) exp_q.push_back(8'(s[k]));
        if (c < n - 1) exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(3))
      0: return $urandom % 10;
      1: return $urandom % 100;
      2: return $urandom % 256;
      default: return $urandom;
    endcase
  endfunction

  task automatic run(input string name, input logic [7:0] base, input logic [31:0] m,
                     input logic [31:0] n, input int ready_pct, input bit exp_err,
                     input bit chk_addr, input bit busy_starts, input int abort_after);
    bit done_seen = 0, hold = 0, valid_seen = 0;
    logic [7:0] hold_byte = '0, last_addr;
    if (!exp_err) build_expected(base, int'(m), int'(n));
    else begin
      exp_q.delete();
      exp_addr.delete();
    end
    got_q.delete();
    got_addr.delete();
    @(negedge clk);
    last_addr = o_rd_addr;
    i_start = 1'b1; i_base_addr = base; i_m = m; i_n = n;
    i_byte_ready = ($urandom_range(99) < ready_pct);
    for (int cyc = 0; cyc < BUDGET && !done_seen; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      i_base_addr = 8'($urandom); i_m = $urandom_range(9); i_n = $urandom_range(9);
      if (cyc == 0) begin
        n_cmp++;
        if (o_busy !== 1'b1) begin
          n_bad++; $display("FAIL %s busy_after_start: got %b want 1", name, o_busy);
        end
      end
      if (hold) begin
        n_cmp++;
        if (o_byte_valid !== 1'b1 || o_byte !== hold_byte) begin
          n_bad++;
          $display("FAIL %s stall_stable: got v=%b b=%h want v=1 b=%h", name, o_byte_valid, o_byte, hold_byte);
        end
      end
      if (o_done === 1'b1) begin
        done_seen = 1;
        n_cmp++;
        if (o_err !== exp_err || o_busy !== 1'b0) begin
          n_bad++;
          $display("FAIL %s done_flags: got err=%b busy=%b want err=%b busy=0", name, o_err, o_busy, exp_err);
        end
      end else begin
        if (o_byte_valid === 1'b1) valid_seen = 1;
        if (o_rd_addr !== last_addr) begin
          got_addr.push_back(o_rd_addr);
          last_addr = o_rd_addr;
        end
        if (busy_starts && o_busy && $urandom_range(9) == 0) begin
          i_start = 1'b1; i_m = 32'd1; i_n = 32'd1;
        end
        i_byte_ready = ($urandom_range(99) < ready_pct);
        hold = o_byte_valid && !i_byte_ready;
        hold_byte = o_byte;
        if (o_byte_valid && i_byte_ready) got_q.push_back(o_byte);
        if (abort_after > 0 && got_q.size() == abort_after) return;
      end
    end
    i_start = 1'b0;
    i_byte_ready = 1'b1;
    n_cmp++;
    if (!done_seen) begin
      n_bad++; $display("FAIL %s timeout: got no done want done within %0d cycles", name, BUDGET);
    end
    @(negedge clk);
    n_cmp++;
    if (o_done !== 1'b0 || o_err !== 1'b0) begin
      n_bad++; $display("FAIL %s done_width: got done=%b err=%b want 0 0", name, o_done, o_err);
    end
    if (exp_err) begin
      n_cmp++;
      if (valid_seen) begin
        n_bad++; $display("FAIL %s err_no_bytes: got valid high want never", name);
      end
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL %s byte_count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++; $display("FAIL %s byte[%0d]: got %h want %h", name, i, got_q[i], exp_q[i]);
      end
    end
    if (chk_addr) begin
      n_cmp++;
      if (got_addr.size() != exp_addr.size()) begin
        n_bad++; $display("FAIL %s addr_count: got %0d want %0d", name, got_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
        n_cmp++;
        if (got_addr[i] !== exp_addr[i]) begin
          n_bad++; $display("FAIL %s addr[%0d]: got %h want %h", name, i, got_addr[i], exp_addr[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (o_byte_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_err !== 1'b0 ||
        o_rd_addr !== 8'h00 || o_byte !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b busy=%b done=%b err=%b addr=%h byte=%h want all 0",
               o_byte_valid, o_busy, o_done, o_err, o_rd_addr, o_byte);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] lit [14] = '{8'h31, 8'h20, 8'h32, 8'h20, 8'h33, 8'h0D, 8'h0A,
                             8'h34, 8'h20, 8'h35, 8'h20, 8'h36, 8'h0D, 8'h0A};
    for (int i = 0; i < 6; i++) mem[8'h10 + i] = 32'(i + 1);
    run("basic", 8'h10, 32'd2, 32'd3, 100, 0, 1, 0, 0);
    for (int i = 0; i < 14 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== lit[i]) begin
        n_bad++; $display("FAIL basic_literal[%0d]: got %h want %h", i, got_q[i], lit[i]);
      end
    end
  endtask

  task automatic test_saturation();
    mem[8'h40] = 32'd255; mem[8'h41] = 32'd100; mem[8'h42] = 32'd7; mem[8'h43] = 32'd300;
    run("sat_1x4", 8'h40, 32'd1, 32'd4, 100, 0, 1, 0, 0);
    mem[8'h50] = 32'd0;
    run("zero_1x1", 8'h50, 32'd1, 32'd1, 100, 0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 6; i++) mem[8'h10 + i] = 32'(i + 1);
    run("backpressure", 8'h10, 32'd2, 32'd3, 30, 0, 1, 1, 0);
  endtask

  task automatic test_errors();
    run("err_m0", 8'h20, 32'd0, 32'd3, 100, 1, 1, 0, 0);
    run("err_n6", 8'h20, 32'd2, 32'd6, 100, 1, 1, 0, 0);
    run("err_m6", 8'h20, 32'd6, 32'd1, 100, 1, 1, 0, 0);
    run("err_bigm", 8'h20, 32'h0000_0102, 32'd2, 100, 1, 1, 0, 0);
  endtask

  task automatic test_wrap();
    mem[8'hFE] = 32'd9; mem[8'hFF] = 32'd42; mem[8'h00] = 32'd128; mem[8'h01] = 32'd1000;
    run("wrap", 8'hFE, 32'd2, 32'd2, 100, 0, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) mem[8'h10 + i] = 32'(i + 1);
    run("abort", 8'h10, 32'd2, 32'd3, 100, 0, 0, 0, 5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (o_byte_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_after_rst: got v=%b busy=%b done=%b want 0 0 0", o_byte_valid, o_busy, o_done);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (o_done !== 1'b0 || o_byte_valid !== 1'b0) begin
        n_bad++; $display("FAIL abort_quiet: got done=%b v=%b want 0 0", o_done, o_byte_valid);
      end
    end
    run("restart", 8'h10, 32'd2, 32'd3, 100, 0, 1, 0, 0);
  endtask

  task automatic test_random();
    logic [7:0] base;
    int m, n;
    for (int t = 0; t < 6; t++) begin
      base = 8'($urandom);
      m = $urandom_range(5, 1);
      n = $urandom_range(5, 1);
      for (int i = 0; i < m * n; i++) mem[8'(int'(base) + i)] = rand_val();
      run($sformatf("rand%0d_%0dx%0d", t, m, n), base, 32'(m), 32'(n),
          $urandom_range(100, 40), 0, 1, 1, 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_errors();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
